uart_tx_cfg: RTL

UART_TX_CFG -- requirements
Module: uart_tx_cfg

---
 rtl/uart_tx_cfg.sv | 139 +++++++++++++
 1 files changed

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: configurable UART transmitter, framed as start/data/parity/stop.
// Ports: clk, rst (async active-low), data_in/data_valid/data_ready handshake, tx serial out, busy.
module uart_tx_cfg #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 data_valid,
  output logic                 data_ready,
  output logic                 tx,
  output logic                 busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST_TICK = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PAR,
    ST_STOP
  } state_t;

  state_t               state;
  state_t               stateNxt;
  logic [CW-1:0]        cnt;
  logic [CW-1:0]        cntNxt;
  logic [3:0]           bitIdx;
  logic [3:0]           bitNxt;
  logic [DATA_BITS-1:0] shiftReg;
  logic [DATA_BITS-1:0] shiftNxt;
  logic                 parBit;
  logic                 parNxt;
  logic                 txNxt;
  logic                 lastTick;

  assign lastTick = (cnt == LAST_TICK);

  // tx is computed one cycle ahead and registered, so it only
  // ever changes on the edge that starts a new bit.
  always_comb begin
    stateNxt = state;
    cntNxt   = lastTick ? '0 : cnt + 1'b1;
    bitNxt   = bitIdx;
    shiftNxt = shiftReg;
    parNxt   = parBit;
    txNxt    = tx;
    unique case (state)
      ST_IDLE: begin
        cntNxt = '0;
        bitNxt = '0;
        txNxt  = 1'b1;
        if (data_valid && data_ready) begin
          shiftNxt = data_in;
          parNxt   = (PARITY == 1) ? ~(^data_in) : ^data_in;
          stateNxt = ST_START;
          txNxt    = 1'b0;
        end
      end
      ST_START: begin
        if (lastTick) begin
          stateNxt = ST_DATA;
          bitNxt   = '0;
          txNxt    = shiftReg[0];
        end
      end
      ST_DATA: begin
        if (lastTick) begin
          if (bitIdx == LAST_DATA) begin
            bitNxt = '0;
            if (PARITY != 0) begin
              stateNxt = ST_PAR;
              txNxt    = parBit;
            end else begin
              stateNxt = ST_STOP;
              txNxt    = 1'b1;
            end
          end else begin
            bitNxt   = bitIdx + 4'd1;
            shiftNxt = shiftReg >> 1;
            txNxt    = shiftReg[1];
          end
        end
      end
      ST_PAR: begin
        if (lastTick) begin
          stateNxt = ST_STOP;
          bitNxt   = '0;
          txNxt    = 1'b1;
        end
      end
      ST_STOP: begin
        if (lastTick) begin
          if (bitIdx == LAST_STOP) begin
            stateNxt = ST_IDLE;
            bitNxt   = '0;
          end else begin
            bitNxt = bitIdx + 4'd1;
          end
          txNxt = 1'b1;
        end
      end
      default: begin
        stateNxt = ST_IDLE;
        txNxt    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      bitIdx     <= '0;
      shiftReg   <= '0;
      parBit     <= 1'b0;
      tx         <= 1'b1;
      data_ready <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= stateNxt;
      cnt        <= cntNxt;
      bitIdx     <= bitNxt;
      shiftReg   <= shiftNxt;
      parBit     <= parNxt;
      tx         <= txNxt;
      data_ready <= (stateNxt == ST_IDLE);
      busy       <= (stateNxt != ST_IDLE);
    end
  end

endmodule
